// File: rtl/btn_pkg.sv
// ============================================================
// Package : btn_pkg
// Desc    : shared types and helpers for the button conditioner
// Rev     : 1.0  initial release
// ============================================================
`default_nettype none

package btn_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_WAIT = 2'd1,
        REPEAT    = 2'd2,
        HELD      = 2'd3
    } chan_state_t;

    // Bits needed to hold the values 0..max_val inclusive (minimum 1).
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_channel.sv
// ============================================================
// Module : btn_channel
// Desc   : synchronizer, debouncer and press/repeat FSM for one button
// Rev    : 1.0  initial release
// ============================================================
`default_nettype none

module btn_channel
    import btn_pkg::*;
#(
    parameter int DBNC_CNT_MAX = 1000,
    parameter int RPT_DELAY    = 0,
    parameter int RPT_PERIOD   = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse,
    output logic level
);

    localparam int c_dbnc_w  = cnt_width(DBNC_CNT_MAX);
    localparam int c_tmr_max = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int c_tmr_w   = cnt_width(c_tmr_max);

    localparam logic [c_dbnc_w-1:0] c_dbnc_max  = c_dbnc_w'(DBNC_CNT_MAX);
    localparam logic [c_tmr_w-1:0]  c_delay_end = c_tmr_w'((RPT_DELAY > 0) ? RPT_DELAY - 1 : 0);
    localparam logic [c_tmr_w-1:0]  c_per_end   = c_tmr_w'((RPT_PERIOD > 0) ? RPT_PERIOD - 1 : 0);

    logic [1:0]          r_sync;
    logic                r_deb;
    logic [c_dbnc_w-1:0] r_dcnt;
    chan_state_t         r_state;
    chan_state_t         w_state_next;
    logic [c_tmr_w-1:0]  r_tmr;
    logic [c_tmr_w-1:0]  w_tmr_next;

    logic w_synced;
    logic w_dbnc_done;
    logic w_rise;
    logic w_fall;

    assign w_synced    = r_sync[1];
    assign w_dbnc_done = (w_synced != r_deb) && (r_dcnt == c_dbnc_max);
    assign w_rise      = w_dbnc_done & ~r_deb;
    assign w_fall      = w_dbnc_done & r_deb;

    // Level as it will be after this edge, so the top can register chord and
    // pulses in the same cycle the debounced level changes.
    assign level = r_deb ^ w_dbnc_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_deb   <= 1'b0;
            r_dcnt  <= '0;
            r_state <= IDLE;
            r_tmr   <= '0;
        end else begin
            r_sync  <= {r_sync[0], raw};
            if (w_synced == r_deb) begin
                r_dcnt <= '0;
            end else if (w_dbnc_done) begin
                r_deb  <= ~r_deb;
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end
            r_state <= w_state_next;
            r_tmr   <= w_tmr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tmr_next   = r_tmr;
        pulse        = 1'b0;
        // A release always wins over a repeat falling due in the same cycle.
        if (w_fall) begin
            w_state_next = IDLE;
            w_tmr_next   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_tmr_next = '0;
                    if (w_rise) begin
                        pulse        = 1'b1;
                        w_state_next = (RPT_DELAY > 0) ? HOLD_WAIT : HELD;
                    end
                end
                HOLD_WAIT: begin
                    if (r_tmr == c_delay_end) begin
                        pulse        = 1'b1;
                        w_tmr_next   = '0;
                        w_state_next = REPEAT;
                    end else begin
                        w_tmr_next = r_tmr + 1'b1;
                    end
                end
                REPEAT: begin
                    if (r_tmr == c_per_end) begin
                        pulse      = 1'b1;
                        w_tmr_next = '0;
                    end else begin
                        w_tmr_next = r_tmr + 1'b1;
                    end
                end
                HELD: begin
                    w_tmr_next = '0;
                end
                default: begin
                    w_state_next = IDLE;
                    w_tmr_next   = '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/btn_conditioner.sv
// ============================================================
// Module : btn_conditioner
// Desc   : two button channels, chord suppression, registered outputs
// Rev    : 1.0  initial release
// ============================================================
`default_nettype none

module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DBNC_CNT_MAX = 1000,
    parameter int RPT_DELAY    = 0,
    parameter int RPT_PERIOD   = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_raw,
    input  logic btn_dn_raw,
    output logic incr_duty,
    output logic decr_duty,
    output logic chord
);

    logic w_up_pulse;
    logic w_up_level;
    logic w_dn_pulse;
    logic w_dn_level;
    logic w_chord_next;

    btn_channel #(
        .DBNC_CNT_MAX (DBNC_CNT_MAX),
        .RPT_DELAY    (RPT_DELAY),
        .RPT_PERIOD   (RPT_PERIOD)
    ) u_up (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_up_raw),
        .pulse (w_up_pulse),
        .level (w_up_level)
    );

    btn_channel #(
        .DBNC_CNT_MAX (DBNC_CNT_MAX),
        .RPT_DELAY    (RPT_DELAY),
        .RPT_PERIOD   (RPT_PERIOD)
    ) u_dn (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_dn_raw),
        .pulse (w_dn_pulse),
        .level (w_dn_level)
    );

    // Masking uses the chord value registered alongside the pulses so that
    // both outputs are zero in exactly the cycles chord is high.
    assign w_chord_next = w_up_level & w_dn_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            chord     <= 1'b0;
            incr_duty <= 1'b0;
            decr_duty <= 1'b0;
        end else begin
            chord     <= w_chord_next;
            incr_duty <= w_up_pulse & ~w_chord_next;
            decr_duty <= w_dn_pulse & ~w_chord_next;
        end
    end

endmodule

`default_nettype wire
